// File: rtl/syncfifo3_prog.sv
// Single-clock FIFO of any depth with optional registered output stage,
// programmable almost flags, sticky error status, drop counter and high-water mark.
module syncfifo3_prog #(
    parameter int WID    = 32,
    parameter int DEPTH  = 8,
    parameter int AWID   = $clog2(DEPTH),
    parameter int REGOUT = 0,
    parameter int CNTW   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            softreset,
    input  logic            validin,
    input  logic [WID-1:0]  datain,
    input  logic            readout,
    output logic [WID-1:0]  dataout,
    output logic            empty,
    output logic            full,
    output logic [AWID:0]   count,
    input  logic [AWID:0]   afull_thr,
    input  logic [AWID:0]   aempty_thr,
    output logic            almost_full,
    output logic            almost_empty,
    output logic            overflow,
    output logic            underflow,
    output logic            ovf_sticky,
    output logic            udf_sticky,
    output logic [CNTW-1:0] drop_cnt,
    output logic [AWID:0]   hwm,
    input  logic            clr_status
);

    localparam logic [AWID-1:0] LAST     = AWID'(DEPTH - 1);
    localparam logic [AWID:0]   FULL_CNT = (AWID+1)'(DEPTH);
    localparam logic [CNTW-1:0] DROP_MAX = '1;

    logic [WID-1:0]  mem [DEPTH];
    logic [AWID-1:0] wptr, rptr;
    logic            wr, rd, mem_pop;
    logic [AWID:0]   count_nxt;

    // Explicit wrap keeps the pointers correct for non-power-of-two depths.
    function automatic logic [AWID-1:0] ptr_inc(input logic [AWID-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign full         = (count == FULL_CNT);
    assign wr           = validin && !full && !softreset;
    assign rd           = readout && !empty && !softreset;
    assign overflow     = validin && full && !softreset;
    assign underflow    = readout && empty && !softreset;
    assign almost_full  = (count >= afull_thr);
    assign almost_empty = (count <= aempty_thr);

    always_comb begin
        count_nxt = count;
        if (softreset)      count_nxt = '0;
        else if (wr && !rd) count_nxt = count + 1'b1;
        else if (rd && !wr) count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= datain;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            count <= count_nxt;
            if (softreset) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (wr)      wptr <= ptr_inc(wptr);
                if (mem_pop) rptr <= ptr_inc(rptr);
            end
        end
    end

    generate
        if (REGOUT == 0) begin : g_comb
            assign mem_pop = rd;
            assign empty   = (count == '0);
            assign dataout = mem[rptr];
        end else begin : g_reg
            logic           vld;
            logic [WID-1:0] hold;
            logic [AWID:0]  mem_cnt;

            // count includes the holding register, so memory occupancy excludes it.
            assign mem_cnt = count - (AWID+1)'(vld);
            assign mem_pop = !softreset && (!vld || rd) && (mem_cnt != '0);
            assign empty   = !vld;
            assign dataout = hold;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld  <= 1'b0;
                    hold <= '0;
                end else if (softreset) begin
                    vld  <= 1'b0;
                    hold <= '0;
                end else if (mem_pop) begin
                    vld  <= 1'b1;
                    hold <= mem[rptr];
                end else if (rd) begin
                    vld  <= 1'b0;
                end
            end
        end
    endgenerate

    // A fresh error in the clearing cycle wins over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
            udf_sticky <= 1'b0;
            drop_cnt   <= '0;
            hwm        <= '0;
        end else if (softreset) begin
            ovf_sticky <= 1'b0;
            udf_sticky <= 1'b0;
            drop_cnt   <= '0;
            hwm        <= '0;
        end else begin
            ovf_sticky <= overflow  || (ovf_sticky && !clr_status);
            udf_sticky <= underflow || (udf_sticky && !clr_status);
            if (overflow)
                drop_cnt <= clr_status ? CNTW'(1) :
                            (drop_cnt == DROP_MAX) ? DROP_MAX : drop_cnt + 1'b1;
            else if (clr_status)
                drop_cnt <= '0;
            if (clr_status)
                hwm <= count_nxt;
            else if (count_nxt > hwm)
                hwm <= count_nxt;
        end
    end

endmodule

// File: tb/tb_syncfifo3_prog.sv
// Directed bench: DEPTH=5 combinational-output instance (a) and DEPTH=8 registered-output instance (b).
module tb_syncfifo3_prog;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic       sr_a, vi_a, ro_a, clr_a;
    logic [7:0] di_a, do_a, dc_a;
    logic [3:0] aft_a, aet_a, cnt_a, hwm_a;
    logic       em_a, fu_a, af_a, ae_a, ov_a, un_a, os_a, us_a;

    logic       sr_b, vi_b, ro_b, clr_b;
    logic [7:0] di_b, do_b, dc_b;
    logic [3:0] aft_b, aet_b, cnt_b, hwm_b;
    logic       em_b, fu_b, af_b, ae_b, ov_b, un_b, os_b, us_b;

    syncfifo3_prog #(.WID(8), .DEPTH(5), .REGOUT(0), .CNTW(8)) u_a (
        .clk(clk), .rst_n(rst_n), .softreset(sr_a), .validin(vi_a), .datain(di_a),
        .readout(ro_a), .dataout(do_a), .empty(em_a), .full(fu_a), .count(cnt_a),
        .afull_thr(aft_a), .aempty_thr(aet_a), .almost_full(af_a), .almost_empty(ae_a),
        .overflow(ov_a), .underflow(un_a), .ovf_sticky(os_a), .udf_sticky(us_a),
        .drop_cnt(dc_a), .hwm(hwm_a), .clr_status(clr_a));

    syncfifo3_prog #(.WID(8), .DEPTH(8), .REGOUT(1), .CNTW(8)) u_b (
        .clk(clk), .rst_n(rst_n), .softreset(sr_b), .validin(vi_b), .datain(di_b),
        .readout(ro_b), .dataout(do_b), .empty(em_b), .full(fu_b), .count(cnt_b),
        .afull_thr(aft_b), .aempty_thr(aet_b), .almost_full(af_b), .almost_empty(ae_b),
        .overflow(ov_b), .underflow(un_b), .ovf_sticky(os_b), .udf_sticky(us_b),
        .drop_cnt(dc_b), .hwm(hwm_b), .clr_status(clr_b));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        // {count, empty, full, ovf, udf, ovs, uds, drop, hwm, ae, af}
        n_cmp++;
        if ({cnt_a, em_a, fu_a, ov_a, un_a, os_a, us_a, dc_a, hwm_a, ae_a, af_a}
            !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_a cnt=%0d em=%b fu=%b ov=%b un=%b os=%b us=%b dc=%0d hwm=%0d ae=%b af=%b required cnt=0 em=1 others 0 ae=1",
                     cnt_a, em_a, fu_a, ov_a, un_a, os_a, us_a, dc_a, hwm_a, ae_a, af_a);
        end
        // afull_thr=0 on b: almost_full must be 1 even when empty
        n_cmp++;
        if ({cnt_b, em_b, fu_b, do_b, dc_b, hwm_b, ae_b, af_b}
            !== {4'd0, 1'b1, 1'b0, 8'd0, 8'd0, 4'd0, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_b cnt=%0d em=%b fu=%b do=%h dc=%0d hwm=%0d ae=%b af=%b required 0 1 0 00 0 0 1 1",
                     cnt_b, em_b, fu_b, do_b, dc_b, hwm_b, ae_b, af_b);
        end
    endtask

    task automatic test_fill_drain;
        for (int i = 1; i <= 5; i++) begin
            vi_a = 1'b1; di_a = 8'(i);
            tick;
        end
        vi_a = 1'b0;
        n_cmp++;
        if ({fu_a, cnt_a} !== {1'b1, 4'd5}) begin
            n_bad++;
            $display("FAIL fill_full fu=%b cnt=%0d required fu=1 cnt=5", fu_a, cnt_a);
        end
        vi_a = 1'b1; di_a = 8'd6;
        #1;
        n_cmp++;
        if (ov_a !== 1'b1) begin
            n_bad++;
            $display("FAIL fill_ovf_pulse ov=%b required 1", ov_a);
        end
        tick;
        vi_a = 1'b0;
        n_cmp++;
        if ({dc_a, os_a, cnt_a} !== {8'd1, 1'b1, 4'd5}) begin
            n_bad++;
            $display("FAIL fill_drop dc=%0d os=%b cnt=%0d required 1 1 5", dc_a, os_a, cnt_a);
        end
        for (int i = 1; i <= 5; i++) begin
            n_cmp++;
            if ({em_a, do_a} !== {1'b0, 8'(i)}) begin
                n_bad++;
                $display("FAIL drain_data[%0d] em=%b do=%0d required em=0 do=%0d", i, em_a, do_a, i);
            end
            ro_a = 1'b1;
            tick;
        end
        ro_a = 1'b0;
        n_cmp++;
        if ({em_a, cnt_a, hwm_a} !== {1'b1, 4'd0, 4'd5}) begin
            n_bad++;
            $display("FAIL drain_end em=%b cnt=%0d hwm=%0d required 1 0 5", em_a, cnt_a, hwm_a);
        end
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 3; i++) begin
            vi_a = 1'b1; di_a = 8'(10 + i);
            tick;
        end
        for (int k = 0; k < 20; k++) begin
            vi_a = 1'b1; ro_a = 1'b1; di_a = 8'(13 + k);
            #1;
            n_cmp++;
            if ({cnt_a, do_a} !== {4'd3, 8'(10 + k)}) begin
                n_bad++;
                $display("FAIL wrap[%0d] cnt=%0d do=%0d required cnt=3 do=%0d", k, cnt_a, do_a, 10 + k);
            end
            tick;
        end
        vi_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ro_a = 1'b1;
            #1;
            n_cmp++;
            if (do_a !== 8'(30 + k)) begin
                n_bad++;
                $display("FAIL wrap_drain[%0d] do=%0d required %0d", k, do_a, 30 + k);
            end
            tick;
        end
        ro_a = 1'b0;
        n_cmp++;
        if ({em_a, cnt_a} !== {1'b1, 4'd0}) begin
            n_bad++;
            $display("FAIL wrap_empty em=%b cnt=%0d required 1 0", em_a, cnt_a);
        end
    endtask

    task automatic test_errors;
        ro_a = 1'b1;
        #1;
        n_cmp++;
        if (un_a !== 1'b1) begin
            n_bad++;
            $display("FAIL udf_pulse un=%b required 1", un_a);
        end
        tick;
        ro_a = 1'b0;
        n_cmp++;
        if ({us_a, cnt_a} !== {1'b1, 4'd0}) begin
            n_bad++;
            $display("FAIL udf_sticky us=%b cnt=%0d required 1 0", us_a, cnt_a);
        end
        vi_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            di_a = 8'(40 + i);
            tick;
        end
        // drop_cnt was cleared? no: it still holds 1 from fill_drain, so 300 more saturates
        for (int i = 0; i < 300; i++) tick;
        n_cmp++;
        if ({dc_a, os_a, cnt_a} !== {8'd255, 1'b1, 4'd5}) begin
            n_bad++;
            $display("FAIL drop_sat dc=%0d os=%b cnt=%0d required 255 1 5", dc_a, os_a, cnt_a);
        end
        clr_a = 1'b1;
        tick;
        n_cmp++;
        if ({dc_a, os_a, us_a} !== {8'd1, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL clr_with_ovf dc=%0d os=%b us=%b required 1 1 0", dc_a, os_a, us_a);
        end
        vi_a = 1'b0;
        tick;
        clr_a = 1'b0;
        n_cmp++;
        if ({dc_a, os_a, cnt_a} !== {8'd0, 1'b0, 4'd5}) begin
            n_bad++;
            $display("FAIL clr_plain dc=%0d os=%b cnt=%0d required 0 0 5", dc_a, os_a, cnt_a);
        end
        n_cmp++;
        if (do_a !== 8'd40) begin
            n_bad++;
            $display("FAIL full_head do=%0d required 40", do_a);
        end
    endtask

    task automatic test_regout_latency;
        vi_b = 1'b1; di_b = 8'hA5;
        tick;
        vi_b = 1'b0;
        n_cmp++;
        if ({em_b, cnt_b} !== {1'b1, 4'd1}) begin
            n_bad++;
            $display("FAIL reg_lat_n em=%b cnt=%0d required 1 1", em_b, cnt_b);
        end
        ro_b = 1'b1;
        #1;
        n_cmp++;
        if (un_b !== 1'b1) begin
            n_bad++;
            $display("FAIL reg_lat_udf un=%b required 1", un_b);
        end
        tick;
        ro_b = 1'b0;
        n_cmp++;
        if ({em_b, do_b, cnt_b} !== {1'b0, 8'hA5, 4'd1}) begin
            n_bad++;
            $display("FAIL reg_lat_n1 em=%b do=%h cnt=%0d required 0 a5 1", em_b, do_b, cnt_b);
        end
        ro_b = 1'b1;
        tick;
        ro_b = 1'b0;
        n_cmp++;
        if ({em_b, cnt_b, us_b} !== {1'b1, 4'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL reg_lat_read em=%b cnt=%0d us=%b required 1 0 1", em_b, cnt_b, us_b);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 3; i++) begin
            vi_b = 1'b1; di_b = 8'(20 + i);
            tick;
        end
        for (int k = 0; k < 8; k++) begin
            vi_b = 1'b1; ro_b = 1'b1; di_b = 8'(23 + k);
            #1;
            n_cmp++;
            if ({em_b, do_b, cnt_b} !== {1'b0, 8'(20 + k), 4'd3}) begin
                n_bad++;
                $display("FAIL b2b[%0d] em=%b do=%0d cnt=%0d required 0 %0d 3", k, em_b, do_b, cnt_b, 20 + k);
            end
            tick;
        end
        vi_b = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ro_b = 1'b1;
            #1;
            n_cmp++;
            if ({em_b, do_b} !== {1'b0, 8'(28 + k)}) begin
                n_bad++;
                $display("FAIL b2b_drain[%0d] em=%b do=%0d required 0 %0d", k, em_b, do_b, 28 + k);
            end
            tick;
        end
        ro_b = 1'b0;
        n_cmp++;
        if ({em_b, cnt_b} !== {1'b1, 4'd0}) begin
            n_bad++;
            $display("FAIL b2b_empty em=%b cnt=%0d required 1 0", em_b, cnt_b);
        end
    endtask

    task automatic test_thresholds;
        aft_b = 4'd6; aet_b = 4'd2;
        for (int c = 0; c <= 8; c++) begin
            #1;
            n_cmp++;
            if ({cnt_b, ae_b, af_b, fu_b} !== {4'(c), c <= 2, c >= 6, c == 8}) begin
                n_bad++;
                $display("FAIL thr[%0d] cnt=%0d ae=%b af=%b fu=%b required ae=%b af=%b fu=%b",
                         c, cnt_b, ae_b, af_b, fu_b, c <= 2, c >= 6, c == 8);
            end
            if (c < 8) begin
                vi_b = 1'b1; di_b = 8'(50 + c);
                tick;
                vi_b = 1'b0;
            end
        end
        aet_b = 4'd8;
        #1;
        n_cmp++;
        if (ae_b !== 1'b1) begin
            n_bad++;
            $display("FAIL thr_ae_max ae=%b required 1", ae_b);
        end
        aet_b = 4'd2;
    endtask

    task automatic test_softreset;
        sr_b = 1'b1;
        tick;
        sr_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vi_b = 1'b1; di_b = 8'(60 + i);
            tick;
        end
        n_cmp++;
        if ({cnt_b, hwm_b} !== {4'd4, 4'd4}) begin
            n_bad++;
            $display("FAIL sr_pre cnt=%0d hwm=%0d required 4 4", cnt_b, hwm_b);
        end
        sr_b = 1'b1; vi_b = 1'b1; ro_b = 1'b1; di_b = 8'd77;
        tick;
        sr_b = 1'b0; vi_b = 1'b0; ro_b = 1'b0;
        n_cmp++;
        if ({cnt_b, em_b, fu_b, hwm_b, dc_b, os_b, us_b, do_b}
            !== {4'd0, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL sr_clear cnt=%0d em=%b fu=%b hwm=%0d dc=%0d os=%b us=%b do=%h required 0 1 0 0 0 0 0 00",
                     cnt_b, em_b, fu_b, hwm_b, dc_b, os_b, us_b, do_b);
        end
        tick;
        tick;
        n_cmp++;
        if ({cnt_b, em_b} !== {4'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL sr_no_write cnt=%0d em=%b required 0 1", cnt_b, em_b);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {sr_a, vi_a, ro_a, clr_a, di_a} = '0;
        {sr_b, vi_b, ro_b, clr_b, di_b} = '0;
        aft_a = 4'd4; aet_a = 4'd1;
        aft_b = 4'd0; aet_b = 4'd2;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        rst_n = 1'b1;
        tick;
        test_reset;
        test_fill_drain;
        test_wrap;
        test_errors;
        test_regout_latency;
        test_back_to_back;
        test_thresholds;
        test_softreset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
